// File: rtl/ucode_mem_arbiter_if.sv
// Request/response and memory-side signals of the uCode memory arbiter.
// slave = arbiter side, master = requester/memory side.
interface ucode_mem_arbiter_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 10
);
    logic               i_cpu_req;
    logic               i_cpu_wr;
    logic [ADDR_SZ-1:0] i_cpu_addr;
    logic [DATA_SZ-1:0] i_cpu_wdata;
    logic               o_cpu_ack;
    logic [DATA_SZ-1:0] o_cpu_rdata;

    logic               i_host_req;
    logic               i_host_wr;
    logic [ADDR_SZ-1:0] i_host_addr;
    logic [DATA_SZ-1:0] i_host_wdata;
    logic               o_host_ack;
    logic [DATA_SZ-1:0] o_host_rdata;
    logic               o_host_err;

    logic               o_mem_wr;
    logic [ADDR_SZ-1:0] o_mem_waddr;
    logic [DATA_SZ-1:0] o_mem_wdata;
    logic [ADDR_SZ-1:0] o_mem_raddr;
    logic [DATA_SZ-1:0] i_mem_rdata;
    logic               o_busy;

    modport slave (
        input  i_cpu_req, i_cpu_wr, i_cpu_addr, i_cpu_wdata,
        input  i_host_req, i_host_wr, i_host_addr, i_host_wdata,
        input  i_mem_rdata,
        output o_cpu_ack, o_cpu_rdata,
        output o_host_ack, o_host_rdata, o_host_err,
        output o_mem_wr, o_mem_waddr, o_mem_wdata, o_mem_raddr, o_busy
    );

    modport master (
        output i_cpu_req, i_cpu_wr, i_cpu_addr, i_cpu_wdata,
        output i_host_req, i_host_wr, i_host_addr, i_host_wdata,
        output i_mem_rdata,
        input  o_cpu_ack, o_cpu_rdata,
        input  o_host_ack, o_host_rdata, o_host_err,
        input  o_mem_wr, o_mem_waddr, o_mem_wdata, o_mem_raddr, o_busy
    );
endinterface

// File: rtl/ucode_mem_arbiter.sv
// CPU-priority arbiter for the shared uCode RAM, host progress bounded by HOST_WAIT_MAX; host write protect via UCODE_WRITE_PROTECT_EN.
// Grant->ack 2 cycles, one transaction per 3 cycles; requesters hold req until their ack.
module ucode_mem_arbiter #(
    parameter int DATA_SZ       = 16,
    parameter int ADDR_SZ       = 10,
    parameter int HOST_WAIT_MAX = 4,
    parameter int PROTECT_TOP   = 'h100
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ucode_mem_arbiter_if.slave io_bus
);
`ifdef UCODE_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif
    localparam logic [7:0]         HWM = 8'(HOST_WAIT_MAX);
    localparam logic [ADDR_SZ-1:0] PT  = ADDR_SZ'(PROTECT_TOP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_win_host;
    logic               r_wr;
    logic [ADDR_SZ-1:0] r_addr;
    logic [DATA_SZ-1:0] r_wdata;
    logic [DATA_SZ-1:0] r_cpu_rdata;
    logic [DATA_SZ-1:0] r_host_rdata;
    logic [7:0]         r_starve;
    logic               w_grant;
    logic               w_host_win;
    logic               w_protect;

    always_comb begin
        w_grant    = io_bus.i_host_req || io_bus.i_cpu_req;
        w_host_win = io_bus.i_host_req && (!io_bus.i_cpu_req || (r_starve == HWM));
        w_protect  = WP_EN && r_win_host && r_wr && (r_addr < PT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_next = ST_ACCESS;
            ST_ACCESS: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win_host   <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_starve     <= 8'd0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_grant) begin
                    r_win_host <= w_host_win;
                    r_wr       <= w_host_win ? io_bus.i_host_wr    : io_bus.i_cpu_wr;
                    r_addr     <= w_host_win ? io_bus.i_host_addr  : io_bus.i_cpu_addr;
                    r_wdata    <= w_host_win ? io_bus.i_host_wdata : io_bus.i_cpu_wdata;
                end
                // Falling through to the increment means host is waiting and CPU just won.
                if ((w_grant && w_host_win) || !io_bus.i_host_req)
                    r_starve <= 8'd0;
                else if (r_starve != HWM)
                    r_starve <= r_starve + 8'd1;
            end
            if (r_state == ST_DONE && !r_wr) begin
                if (r_win_host) r_host_rdata <= io_bus.i_mem_rdata;
                else            r_cpu_rdata  <= io_bus.i_mem_rdata;
            end
        end
    end

    always_comb begin
        io_bus.o_cpu_ack   = 1'b0;
        io_bus.o_host_ack  = 1'b0;
        io_bus.o_host_err  = 1'b0;
        io_bus.o_mem_wr    = 1'b0;
        io_bus.o_mem_waddr = '0;
        io_bus.o_mem_wdata = '0;
        io_bus.o_mem_raddr = '0;
        io_bus.o_busy      = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                io_bus.o_busy      = 1'b1;
                io_bus.o_mem_raddr = r_addr;
                if (r_wr && !w_protect) begin
                    io_bus.o_mem_wr    = 1'b1;
                    io_bus.o_mem_waddr = r_addr;
                    io_bus.o_mem_wdata = r_wdata;
                end
            end
            ST_DONE: begin
                io_bus.o_busy     = 1'b1;
                io_bus.o_cpu_ack  = !r_win_host;
                io_bus.o_host_ack = r_win_host;
                io_bus.o_host_err = w_protect;
            end
            default: ;
        endcase
    end

    assign io_bus.o_cpu_rdata  = r_cpu_rdata;
    assign io_bus.o_host_rdata = r_host_rdata;
endmodule

// File: tb/tb_ucode_mem_arbiter.sv
// Bench for ucode_mem_arbiter: directed vector table, arbitration sequences, mid-access reset,
// and a randomized run against a transaction-level reference model.
module tb_ucode_mem_arbiter;
    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int HWM = 4;
    localparam int NR  = 600;
    localparam int NE  = NR + 8;
`ifdef UCODE_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_pass;
    int   n_tot;

    ucode_mem_arbiter_if #(.DATA_SZ(DW), .ADDR_SZ(AW)) bus();

    ucode_mem_arbiter #(
        .DATA_SZ(DW), .ADDR_SZ(AW), .HOST_WAIT_MAX(HWM), .PROTECT_TOP('h100)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Block RAM with registered read, as seen by the arbiter.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] mem_rd;
    always @(posedge clk) begin
        if (bus.o_mem_wr) mem[bus.o_mem_waddr] <= bus.o_mem_wdata;
        mem_rd <= mem[bus.o_mem_raddr];
    end
    assign bus.i_mem_rdata = mem_rd;

    typedef struct {
        bit          host;
        bit          wr;
        logic [9:0]  addr;
        logic [15:0] wdata;
        bit          exp_err;
        logic [15:0] exp_rd;
    } vec_t;
    vec_t vecs [11];

    logic [DW-1:0] exp_cpu_last;
    logic [DW-1:0] exp_host_last;

    // Random-phase state: per-requester driver (0=cpu, 1=host) and expected events per cycle.
    bit          pend [2];
    int          gap  [2];
    bit          f_wr [2];
    logic [9:0]  f_addr [2];
    logic [15:0] f_dat [2];
    logic [15:0] mm [1024];
    bit          ex_cack [NE];
    bit          ex_hack [NE];
    bit          ex_err  [NE];
    bit          ex_wr   [NE];
    logic [9:0]  ex_wa   [NE];
    logic [15:0] ex_wd   [NE];
    bit          rv_c    [NE];
    bit          rv_h    [NE];
    logic [15:0] rd_c    [NE];
    logic [15:0] rd_h    [NE];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_cpu_req = 1'b0;  bus.i_cpu_wr = 1'b0;  bus.i_cpu_addr = '0;  bus.i_cpu_wdata = '0;
        bus.i_host_req = 1'b0; bus.i_host_wr = 1'b0; bus.i_host_addr = '0; bus.i_host_wdata = '0;
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int cyc;
        int nwr;
        bit acked;
        if (v.host) begin
            bus.i_host_req = 1'b1; bus.i_host_wr = v.wr; bus.i_host_addr = v.addr; bus.i_host_wdata = v.wdata;
        end else begin
            bus.i_cpu_req = 1'b1;  bus.i_cpu_wr = v.wr;  bus.i_cpu_addr = v.addr;  bus.i_cpu_wdata = v.wdata;
        end
        cyc = 0; nwr = 0; acked = 1'b0;
        while (!acked && cyc < 8) begin
            step();
            cyc++;
            if (bus.o_mem_wr) begin
                nwr++;
                chk($sformatf("v%0d_waddr", idx), bus.o_mem_waddr, v.addr);
                chk($sformatf("v%0d_wdata", idx), bus.o_mem_wdata, v.wdata);
            end
            if (v.host ? bus.o_host_ack : bus.o_cpu_ack) begin
                acked = 1'b1;
                chk($sformatf("v%0d_other_ack", idx), v.host ? bus.o_cpu_ack : bus.o_host_ack, 0);
                chk($sformatf("v%0d_host_err", idx), bus.o_host_err, v.exp_err);
            end
        end
        idle_inputs();
        chk($sformatf("v%0d_ack_latency", idx), cyc, 2);
        chk($sformatf("v%0d_wr_pulses", idx), nwr, (v.wr && !v.exp_err) ? 1 : 0);
        step();
        chk($sformatf("v%0d_ack_pulse", idx), bus.o_cpu_ack | bus.o_host_ack, 0);
        if (!v.wr) begin
            if (v.host) exp_host_last = v.exp_rd;
            else        exp_cpu_last  = v.exp_rd;
        end
        chk($sformatf("v%0d_cpu_rdata", idx), bus.o_cpu_rdata, exp_cpu_last);
        chk($sformatf("v%0d_host_rdata", idx), bus.o_host_rdata, exp_host_last);
    endtask

    // Drives req patterns cycle by cycle (bit c = cycle c) and checks ack placement.
    task automatic run_arb(input string nm, input int n, input logic [63:0] con, input logic [63:0] hon,
                           input logic [63:0] cex, input logic [63:0] hex);
        bus.i_cpu_addr = 10'h3F1;
        bus.i_host_addr = 10'h3F2;
        for (int c = 0; c < n; c++) begin
            bus.i_cpu_req  = con[c];
            bus.i_host_req = hon[c];
            chk($sformatf("%s_cpu_ack_c%0d", nm, c), bus.o_cpu_ack, cex[c]);
            chk($sformatf("%s_host_ack_c%0d", nm, c), bus.o_host_ack, hex[c]);
            step();
        end
        idle_inputs();
    endtask

    task automatic new_fields(input int r);
        f_wr[r]   = ($urandom_range(0, 2) == 0);
        f_addr[r] = {($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00, 4'($urandom_range(0, 15))};
        f_dat[r]  = 16'($urandom);
    endtask

    task automatic run_random();
        int          free_at;
        int          starve;
        int          who;
        bit          ak;
        bit          hr;
        bit          cr;
        bit          prot;
        logic [15:0] cur_c;
        logic [15:0] cur_h;
        for (int i = 0; i < NE; i++) begin
            ex_cack[i] = 0; ex_hack[i] = 0; ex_err[i] = 0; ex_wr[i] = 0; rv_c[i] = 0; rv_h[i] = 0;
        end
        for (int i = 0; i < 1024; i++) mm[i] = mem[i];
        pend[0] = 0; pend[1] = 0; gap[0] = 0; gap[1] = 1;
        new_fields(0); new_fields(1);
        free_at = 0; starve = 0; cur_c = '0; cur_h = '0;
        for (int c = 0; c < NR; c++) begin
            if (rv_c[c]) cur_c = rd_c[c];
            if (rv_h[c]) cur_h = rd_h[c];
            chk("rnd_cpu_ack", bus.o_cpu_ack, ex_cack[c]);
            chk("rnd_host_ack", bus.o_host_ack, ex_hack[c]);
            chk("rnd_host_err", bus.o_host_err, ex_err[c]);
            chk("rnd_mem_wr", bus.o_mem_wr, ex_wr[c]);
            if (ex_wr[c]) begin
                chk("rnd_waddr", bus.o_mem_waddr, ex_wa[c]);
                chk("rnd_wdata", bus.o_mem_wdata, ex_wd[c]);
            end
            chk("rnd_cpu_rdata", bus.o_cpu_rdata, cur_c);
            chk("rnd_host_rdata", bus.o_host_rdata, cur_h);
            for (int r = 0; r < 2; r++) begin
                ak = (r == 0) ? bus.o_cpu_ack : bus.o_host_ack;
                if (ak) begin
                    pend[r] = 0;
                    gap[r] = $urandom_range(0, 2);
                end else if (!pend[r]) begin
                    if (gap[r] == 0) begin pend[r] = 1; new_fields(r); end
                    else gap[r]--;
                end else if ($urandom_range(0, 3) == 0) begin
                    new_fields(r);  // fields only matter in the grant cycle
                end
            end
            bus.i_cpu_req  = pend[0]; bus.i_cpu_wr  = f_wr[0]; bus.i_cpu_addr  = f_addr[0]; bus.i_cpu_wdata  = f_dat[0];
            bus.i_host_req = pend[1]; bus.i_host_wr = f_wr[1]; bus.i_host_addr = f_addr[1]; bus.i_host_wdata = f_dat[1];
            if (c >= free_at) begin
                cr = pend[0]; hr = pend[1]; who = -1;
                if (!hr) starve = 0;
                if (hr && (!cr || starve == HWM)) begin
                    who = 1; starve = 0;
                end else if (cr) begin
                    who = 0;
                    if (hr) starve = (starve < HWM) ? starve + 1 : HWM;
                end
                if (who >= 0) begin
                    free_at = c + 3;
                    prot = WP && (who == 1) && f_wr[who] && (f_addr[who] < 10'h100);
                    if (f_wr[who] && !prot) begin
                        mm[f_addr[who]] = f_dat[who];
                        ex_wr[c+1] = 1; ex_wa[c+1] = f_addr[who]; ex_wd[c+1] = f_dat[who];
                    end
                    if (who == 0) ex_cack[c+2] = 1;
                    else          ex_hack[c+2] = 1;
                    ex_err[c+2] = prot;
                    if (!f_wr[who]) begin
                        if (who == 0) begin rv_c[c+3] = 1; rd_c[c+3] = mm[f_addr[who]]; end
                        else          begin rv_h[c+3] = 1; rd_h[c+3] = mm[f_addr[who]]; end
                    end
                end
            end
            step();
        end
        idle_inputs();
        repeat (4) step();
    endtask

    initial begin
        n_pass = 0; n_tot = 0;
        exp_cpu_last = '0; exp_host_last = '0;
        for (int i = 0; i < 1024; i++) mem[i] <= 16'hB000 | 16'(i);
        vecs[0]  = '{0, 0, 10'h012, 16'h0000, 0, 16'hB012};
        vecs[1]  = '{1, 1, 10'h3FF, 16'h5A5A, 0, 16'h0000};
        vecs[2]  = '{1, 0, 10'h3FF, 16'h0000, 0, 16'h5A5A};
        vecs[3]  = '{0, 1, 10'h020, 16'h1111, 0, 16'h0000};
        vecs[4]  = '{0, 0, 10'h020, 16'h0000, 0, 16'h1111};
        vecs[5]  = '{1, 1, 10'h010, 16'hDEAD, WP, 16'h0000};
        vecs[6]  = '{1, 0, 10'h010, 16'h0000, 0, WP ? 16'hB010 : 16'hDEAD};
        vecs[7]  = '{1, 1, 10'h200, 16'h1234, 0, 16'h0000};
        vecs[8]  = '{0, 0, 10'h200, 16'h0000, 0, 16'h1234};
        vecs[9]  = '{0, 1, 10'h010, 16'h7777, 0, 16'h0000};
        vecs[10] = '{1, 0, 10'h010, 16'h0000, 0, 16'h7777};

        idle_inputs();
        rst = 1'b1;
        step(); step();
        chk("rst_cpu_ack", bus.o_cpu_ack, 0);
        chk("rst_host_ack", bus.o_host_ack, 0);
        chk("rst_host_err", bus.o_host_err, 0);
        chk("rst_mem_wr", bus.o_mem_wr, 0);
        chk("rst_waddr", bus.o_mem_waddr, 0);
        chk("rst_wdata", bus.o_mem_wdata, 0);
        chk("rst_raddr", bus.o_mem_raddr, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_cpu_rdata", bus.o_cpu_rdata, 0);
        chk("rst_host_rdata", bus.o_host_rdata, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) do_txn(i, vecs[i]);

        run_arb("pair", 8, 64'h7, 64'h3F, 64'd1 << 2, 64'd1 << 5);
        run_arb("starve", 36, (64'd1 << 33) - 64'd1,
                ((64'd1 << 14) - 64'd1) | (((64'd1 << 32) - 64'd1) ^ ((64'd1 << 17) - 64'd1)),
                (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 8) | (64'd1 << 11) | (64'd1 << 17) |
                (64'd1 << 20) | (64'd1 << 23) | (64'd1 << 26) | (64'd1 << 29),
                (64'd1 << 14) | (64'd1 << 32));

        bus.i_cpu_req = 1'b1; bus.i_cpu_wr = 1'b1; bus.i_cpu_addr = 10'h020; bus.i_cpu_wdata = 16'hBEEF;
        step();
        chk("abort_pre_wr", bus.o_mem_wr, 1);
        chk("abort_pre_busy", bus.o_busy, 1);
        rst = 1'b1;
        idle_inputs();
        step();
        chk("abort_wr", bus.o_mem_wr, 0);
        chk("abort_ack", bus.o_cpu_ack, 0);
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_cpu_rdata", bus.o_cpu_rdata, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_ack", bus.o_cpu_ack, 0);
            chk("abort_no_rewrite", bus.o_mem_wr, 0);
        end
        bus.i_cpu_req = 1'b1; bus.i_cpu_addr = 10'h020;
        step(); step();
        chk("abort_rd_ack", bus.o_cpu_ack, 1);
        idle_inputs();
        step();
        chk("abort_mem_old_or_new",
            (bus.o_cpu_rdata == 16'h1111) || (bus.o_cpu_rdata == 16'hBEEF), 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        run_random();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
